// File: rtl/sevenseg_scan_reader.sv
// Receive side of the multiplexed seven-segment display path. It samples the
// active-low segment and anode bus, waits for each digit to settle, and decodes it back to BCD.
module sevenseg_scan_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_ok,
    output logic [3:0]  err_mark,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        cap_strobe,
    output logic [1:0]  cap_index
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    // Returns {nibble, ok, err}. Only exact encoder patterns are accepted, so a lit dp is unknown.
    function automatic logic [5:0] decode_seg(input logic [7:0] seg);
        logic [5:0] res;
        case (seg)
            8'b00000011: res = {4'h0, 2'b10};
            8'b10011111: res = {4'h1, 2'b10};
            8'b00100101: res = {4'h2, 2'b10};
            8'b00001101: res = {4'h3, 2'b10};
            8'b10011001: res = {4'h4, 2'b10};
            8'b01001001: res = {4'h5, 2'b10};
            8'b01000001: res = {4'h6, 2'b10};
            8'b00011111: res = {4'h7, 2'b10};
            8'b00000001: res = {4'h8, 2'b10};
            8'b00011001: res = {4'h9, 2'b10};
            8'b11111110: res = {4'hF, 2'b01};
            default:     res = {4'hF, 2'b00};
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [3:0]  an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  captured_q, captured_d;
    logic [15:0] stage_digits_q, stage_digits_d;
    logic [3:0]  stage_ok_q, stage_ok_d;
    logic [3:0]  stage_err_q, stage_err_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  digit_ok_q, digit_ok_d;
    logic [3:0]  err_mark_q, err_mark_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_changed_q, frame_changed_d;
    logic        cap_strobe_q, cap_strobe_d;
    logic [1:0]  cap_index_q, cap_index_d;
    logic        first_q, first_d;

    logic        an_valid;
    logic [1:0]  an_idx;
    logic        changed;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]  dec_nib;
    logic        dec_ok;
    logic        dec_err;
    logic        do_capture;

    always_comb begin
        seg_s1_d        = seg_in;
        seg_s2_d        = seg_s1_q;
        seg_prev_d      = seg_s2_q;
        an_s1_d         = an_in;
        an_s2_d         = an_s1_q;
        an_prev_d       = an_s2_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        captured_d      = captured_q;
        stage_digits_d  = stage_digits_q;
        stage_ok_d      = stage_ok_q;
        stage_err_d     = stage_err_q;
        digits_d        = digits_q;
        digit_ok_d      = digit_ok_q;
        err_mark_d      = err_mark_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = 1'b0;
        cap_strobe_d    = 1'b0;
        cap_index_d     = cap_index_q;
        first_d         = first_q;
        do_capture      = 1'b0;

        an_valid = 1'b1;
        an_idx   = 2'd0;
        case (an_s2_q)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_valid = 1'b0;
        endcase

        changed  = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);
        cnt_next = changed ? CNT_W'(1) : cnt_q + CNT_W'(1);
        {dec_nib, dec_ok, dec_err} = decode_seg(seg_s2_q);

        // From IDLE the counter is 0, so cnt_next is 1 whether or not the bus changed.
        if (!an_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == HELD && !changed) begin
            state_d = HELD;
        end else begin
            cnt_d = cnt_next;
            if (cnt_next == CNT_W'(SETTLE_CYCLES)) begin
                do_capture = 1'b1;
                state_d    = HELD;
            end else begin
                state_d = SETTLE;
            end
        end

        if (captured_q == 4'b1111) begin
            frame_valid_d   = 1'b1;
            frame_changed_d = first_q || (stage_digits_q != digits_q);
            first_d         = 1'b0;
            digits_d        = stage_digits_q;
            digit_ok_d      = stage_ok_q;
            err_mark_d      = stage_err_q;
            captured_d      = 4'b0000;
        end

        // Applied after the frame clear so a capture on the frame edge starts the next frame.
        if (do_capture) begin
            captured_d[an_idx]                  = 1'b1;
            stage_digits_d[{an_idx, 2'b00} +: 4] = dec_nib;
            stage_ok_d[an_idx]                  = dec_ok;
            stage_err_d[an_idx]                 = dec_err;
            cap_strobe_d                        = 1'b1;
            cap_index_d                         = an_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            seg_s1_q        <= '0;
            seg_s2_q        <= '0;
            seg_prev_q      <= '0;
            an_s1_q         <= '0;
            an_s2_q         <= '0;
            an_prev_q       <= '0;
            cnt_q           <= '0;
            captured_q      <= '0;
            stage_digits_q  <= '0;
            stage_ok_q      <= '0;
            stage_err_q     <= '0;
            digits_q        <= '0;
            digit_ok_q      <= '0;
            err_mark_q      <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            cap_strobe_q    <= 1'b0;
            cap_index_q     <= '0;
            first_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            seg_s1_q        <= seg_s1_d;
            seg_s2_q        <= seg_s2_d;
            seg_prev_q      <= seg_prev_d;
            an_s1_q         <= an_s1_d;
            an_s2_q         <= an_s2_d;
            an_prev_q       <= an_prev_d;
            cnt_q           <= cnt_d;
            captured_q      <= captured_d;
            stage_digits_q  <= stage_digits_d;
            stage_ok_q      <= stage_ok_d;
            stage_err_q     <= stage_err_d;
            digits_q        <= digits_d;
            digit_ok_q      <= digit_ok_d;
            err_mark_q      <= err_mark_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            cap_strobe_q    <= cap_strobe_d;
            cap_index_q     <= cap_index_d;
            first_q         <= first_d;
        end
    end

    assign digits        = digits_q;
    assign digit_ok      = digit_ok_q;
    assign err_mark      = err_mark_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign cap_strobe    = cap_strobe_q;
    assign cap_index     = cap_index_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Directed bench for sevenseg_scan_reader: scans hand-built digit patterns across the four
// positions and compares the capture timing and the assembled frames against hand-computed values.
module tb_sevenseg_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_ok;
    logic [3:0]  err_mark;
    logic        frame_valid;
    logic        frame_changed;
    logic        cap_strobe;
    logic [1:0]  cap_index;

    int assertCount = 0;
    int failCount   = 0;

    int          frameCount = 0;
    logic        frameChangedSeen = 1'b0;
    logic [15:0] frameDigits = '0;
    logic [3:0]  frameOk = '0;
    logic [3:0]  frameErr = '0;

    logic [7:0] segOf [10];

    always #5 clk = ~clk;

    sevenseg_scan_reader #(
        .SETTLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .an_in(an_in),
        .digits(digits),
        .digit_ok(digit_ok),
        .err_mark(err_mark),
        .frame_valid(frame_valid),
        .frame_changed(frame_changed),
        .cap_strobe(cap_strobe),
        .cap_index(cap_index)
    );

    // Records what the DUT presented on every frame_valid pulse.
    always @(negedge clk) begin
        if (frame_valid) begin
            frameCount++;
            frameChangedSeen = frame_changed;
            frameDigits      = digits;
            frameOk          = digit_ok;
            frameErr         = err_mark;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one bus value for a number of cycles, noting when cap_strobe shows up.
    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg, input int cycles,
                                 output int strobes, output int firstAt, output int lastIndex);
        an_in     = an;
        seg_in    = seg;
        strobes   = 0;
        firstAt   = -1;
        lastIndex = -1;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (cap_strobe) begin
                strobes++;
                if (firstAt < 0) firstAt = i;
                lastIndex = int'(cap_index);
            end
        end
    endtask

    task automatic scanDigit(input int pos, input logic [7:0] seg, input string tag);
        logic [3:0] an;
        int s, f, idx;
        an = 4'b0001 << pos;
        applyStimulus(~an, seg, 10, s, f, idx);
        checkOutput({tag, " strobes"}, s, 1);
        checkOutput({tag, " strobe cycle"}, f, 6);
        checkOutput({tag, " cap_index"}, idx, pos);
    endtask

    task automatic checkFrame(input string tag, input int expCount, input logic [15:0] expDigits,
                              input logic [3:0] expOk, input logic [3:0] expErr, input logic expChanged);
        checkOutput({tag, " frame count"}, frameCount, expCount);
        checkOutput({tag, " digits"}, frameDigits, expDigits);
        checkOutput({tag, " digit_ok"}, frameOk, expOk);
        checkOutput({tag, " err_mark"}, frameErr, expErr);
        checkOutput({tag, " frame_changed"}, frameChangedSeen, expChanged);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, " digits"}, digits, 16'h0000);
        checkOutput({tag, " digit_ok"}, digit_ok, 4'h0);
        checkOutput({tag, " err_mark"}, err_mark, 4'h0);
        checkOutput({tag, " frame_valid"}, frame_valid, 1'b0);
        checkOutput({tag, " frame_changed"}, frame_changed, 1'b0);
        checkOutput({tag, " cap_strobe"}, cap_strobe, 1'b0);
        checkOutput({tag, " cap_index"}, cap_index, 2'd0);
    endtask

    initial begin
        int s, f, idx;

        segOf[0] = 8'b00000011; segOf[1] = 8'b10011111; segOf[2] = 8'b00100101;
        segOf[3] = 8'b00001101; segOf[4] = 8'b10011001; segOf[5] = 8'b01001001;
        segOf[6] = 8'b01000001; segOf[7] = 8'b00011111; segOf[8] = 8'b00000001;
        segOf[9] = 8'b00011001;

        rst    = 1'b1;
        an_in  = 4'hF;
        seg_in = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkCleared("reset");

        $display("[TB] nominal scan 4321");
        scanDigit(0, segOf[1], "nom p0");
        scanDigit(1, segOf[2], "nom p1");
        scanDigit(2, segOf[3], "nom p2");
        scanDigit(3, segOf[4], "nom p3");
        checkFrame("nom", 1, 16'h4321, 4'hF, 4'h0, 1'b1);

        $display("[TB] repeat frame 4321");
        scanDigit(0, segOf[1], "rep p0");
        scanDigit(1, segOf[2], "rep p1");
        scanDigit(2, segOf[3], "rep p2");
        scanDigit(3, segOf[4], "rep p3");
        checkFrame("rep", 2, 16'h4321, 4'hF, 4'h0, 1'b0);

        $display("[TB] glitch on position 2");
        scanDigit(0, segOf[1], "gl p0");
        scanDigit(1, segOf[2], "gl p1");
        applyStimulus(4'b1011, segOf[3], 3, s, f, idx);
        checkOutput("gl pre-glitch strobes", s, 0);
        applyStimulus(4'b1011, segOf[8], 2, s, f, idx);
        checkOutput("gl during glitch strobes", s, 0);
        applyStimulus(4'b1011, segOf[3], 12, s, f, idx);
        checkOutput("gl post strobes", s, 1);
        checkOutput("gl post strobe cycle", f, 6);
        checkOutput("gl post cap_index", idx, 2);
        scanDigit(3, segOf[4], "gl p3");
        checkFrame("gl", 3, 16'h4321, 4'hF, 4'h0, 1'b0);

        $display("[TB] position 0 changes to 9");
        scanDigit(0, segOf[9], "chg p0");
        scanDigit(1, segOf[2], "chg p1");
        scanDigit(2, segOf[3], "chg p2");
        scanDigit(3, segOf[4], "chg p3");
        checkFrame("chg", 4, 16'h4329, 4'hF, 4'h0, 1'b1);

        $display("[TB] error mark and unknown pattern");
        scanDigit(0, segOf[1], "err p0");
        scanDigit(1, 8'b11111110, "err p1");
        scanDigit(2, segOf[3], "err p2");
        scanDigit(3, 8'b10101010, "err p3");
        checkFrame("err", 5, 16'hF3F1, 4'b0101, 4'b0010, 1'b1);

        $display("[TB] invalid anodes");
        applyStimulus(4'b1111, segOf[8], 5, s, f, idx);
        checkOutput("inv all-ones strobes", s, 0);
        applyStimulus(4'b0011, segOf[8], 5, s, f, idx);
        checkOutput("inv two-low strobes", s, 0);
        checkOutput("inv frame count", frameCount, 5);
        scanDigit(0, segOf[5], "inv recover p0");
        scanDigit(1, segOf[2], "mid p1");

        $display("[TB] reset mid-frame");
        rst    = 1'b1;
        an_in  = 4'hF;
        seg_in = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        checkCleared("mid reset");
        scanDigit(2, segOf[3], "post p2");
        scanDigit(3, segOf[4], "post p3");
        checkOutput("post partial frame count", frameCount, 5);
        scanDigit(0, segOf[1], "post p0");
        scanDigit(1, segOf[2], "post p1");
        repeat (2) @(negedge clk);
        checkFrame("post", 6, 16'h4321, 4'hF, 4'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
